// File: rtl/regfile_arbiter.sv
// Round-robin sequencer sharing one register-file port between master and slave requesters.
// Latency: write ack 2 cycles after grant, read ack 2+RD_LAT, out-of-range ack 1 cycle.
// Backpressure: requests are held by the requester until ack; the loser of a tie stays pending.
module regfile_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RF_DEPTH = 32,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m_req,
    input  logic              m_write,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    output logic              m_ack,
    output logic [DATA_W-1:0] m_rdata,
    input  logic              s_req,
    input  logic              s_write,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_wdata,
    output logic              s_ack,
    output logic [DATA_W-1:0] s_rdata,
    output logic              err,
    output logic [ADDR_W-1:0] rf_address,
    output logic [DATA_W-1:0] rf_data_write,
    output logic              rf_write,
    output logic              rf_exec,
    input  logic [DATA_W-1:0] rf_data_read,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              gid_q, gid_d;
    logic              last_q, last_d;
    logic              wr_q, wr_d;
    logic              oor_q, oor_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] rf_address_q, rf_address_d;
    logic [DATA_W-1:0] rf_data_write_q, rf_data_write_d;
    logic [DATA_W-1:0] m_rdata_q, m_rdata_d;
    logic [DATA_W-1:0] s_rdata_q, s_rdata_d;

    logic              grant_vld;
    logic              grant_sel;
    logic              sel_write;
    logic              sel_oor;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        grant_vld = m_req | s_req;
        // On a tie the port that did not own the previous transaction wins
        grant_sel = (m_req && s_req) ? ~last_q : s_req;
        sel_write = grant_sel ? s_write : m_write;
        sel_addr  = grant_sel ? s_addr  : m_addr;
        sel_wdata = grant_sel ? s_wdata : m_wdata;
        sel_oor   = (sel_addr >= ADDR_W'(RF_DEPTH));

        state_d         = state_q;
        gid_d           = gid_q;
        last_d          = last_q;
        wr_d            = wr_q;
        oor_d           = oor_q;
        cnt_d           = cnt_q;
        rf_address_d    = rf_address_q;
        rf_data_write_d = rf_data_write_q;
        m_rdata_d       = m_rdata_q;
        s_rdata_d       = s_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    gid_d = grant_sel;
                    wr_d  = sel_write;
                    oor_d = sel_oor;
                    if (sel_oor) begin
                        if (grant_sel) s_rdata_d = '0;
                        else           m_rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        rf_address_d    = sel_addr;
                        rf_data_write_d = sel_wdata;
                        state_d         = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (wr_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = 3'(RD_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    if (gid_q) s_rdata_d = rf_data_read;
                    else       m_rdata_d = rf_data_read;
                    state_d = RESP;
                end
            end
            RESP: begin
                last_d  = gid_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            gid_q           <= 1'b0;
            last_q          <= 1'b1;
            wr_q            <= 1'b0;
            oor_q           <= 1'b0;
            cnt_q           <= '0;
            rf_address_q    <= '0;
            rf_data_write_q <= '0;
            m_rdata_q       <= '0;
            s_rdata_q       <= '0;
        end else begin
            state_q         <= state_d;
            gid_q           <= gid_d;
            last_q          <= last_d;
            wr_q            <= wr_d;
            oor_q           <= oor_d;
            cnt_q           <= cnt_d;
            rf_address_q    <= rf_address_d;
            rf_data_write_q <= rf_data_write_d;
            m_rdata_q       <= m_rdata_d;
            s_rdata_q       <= s_rdata_d;
        end
    end

    assign rf_exec       = (state_q == ISSUE);
    assign rf_write      = rf_exec && wr_q;
    assign rf_address    = rf_address_q;
    assign rf_data_write = rf_data_write_q;
    assign m_ack         = (state_q == RESP) && !gid_q;
    assign s_ack         = (state_q == RESP) &&  gid_q;
    assign err           = (state_q == RESP) && oor_q;
    assign m_rdata       = m_rdata_q;
    assign s_rdata       = s_rdata_q;
    assign busy          = (state_q != IDLE);
    assign grant_id      = gid_q;

endmodule
